// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: write port, packed read ports
// and the bulk-clear handshake.
//
// Signals (named as on the register-file datapath):
//   LE/RW/PW : write enable, address, data
//   RA/PA    : NRD packed read addresses / read data
//   Clr      : bulk-clear request
//   Busy     : clear engine running
//   Done     : one-cycle clear-finished pulse
interface param_register_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                  LE;
    logic [ADDR_W-1:0]     RW;
    logic [WIDTH-1:0]      PW;
    logic [NRD*ADDR_W-1:0] RA;
    logic [NRD*WIDTH-1:0]  PA;
    logic                  Clr;
    logic                  Busy;
    logic                  Done;

    modport master (
        output LE, RW, PW, RA, Clr,
        input  PA, Busy, Done
    );

    modport slave (
        input  LE, RW, PW, RA, Clr,
        output PA, Busy, Done
    );
endinterface

// File: rtl/param_register_file.sv
// Parametrised general register file: NRD combinational read ports,
// one synchronous write port, optional hardwired-zero r0 and a
// sequential bulk-clear engine with Busy/Done handshake.
//
// Ports:
//   Clk   : rising-edge clock
//   Rst_n : asynchronous active-low reset (clears all storage)
//   bus   : param_register_file_if.slave (LE/RW/PW, RA/PA, Clr/Busy/Done)
//
// Optional feature: define PARAM_RF_BYPASS_EN to forward the write
// data to any read port addressing the register being written in the
// same cycle (writeback-to-operand forwarding).
module param_register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input logic Clk,
    input logic Rst_n,
    param_register_file_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // r0 needs no clearing when it is hardwired to zero.
    localparam logic [ADDR_W-1:0] FIRST =
        (ZERO_REG != 0) ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              busy;
    logic              done;
    logic              ext_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Addresses that hold real storage (excludes hardwired r0).
    function automatic logic is_real(input logic [ADDR_W-1:0] a);
        return in_range(a) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Clr) begin
                    state_d = S_CLEAR;
                    ptr_d   = FIRST;
                end
            end
            S_CLEAR: begin
                ptr_d = ADDR_W'(ptr_q + 1'b1);
                if (ptr_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The clear engine owns the write port while running; external
    // writes are dropped in that state rather than queued.
    always_comb begin
        busy      = (state_q == S_CLEAR);
        done      = (state_q == S_DONE);
        ext_we    = bus.LE && !busy && is_real(bus.RW);
        mem_we    = busy || ext_we;
        mem_waddr = busy ? ptr_q : bus.RW;
        mem_wdata = busy ? '0 : bus.PW;
    end

    assign bus.Busy = busy;
    assign bus.Done = done;

    // ---------------- Storage ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------- Read ports ----------------
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  rdata;
        bus.PA = '0;
        ra     = '0;
        rdata  = '0;
        for (int i = 0; i < NRD; i++) begin
            ra    = bus.RA[i*ADDR_W +: ADDR_W];
            rdata = '0;
            if (is_real(ra)) begin
                rdata = mem_q[ra];
            end
`ifdef PARAM_RF_BYPASS_EN
            // Gated by Rst_n so every lane reads 0 while in reset.
            if (Rst_n && ext_we && (ra == bus.RW)) begin
                rdata = bus.PW;
            end
`else
`endif
            bus.PA[i*WIDTH +: WIDTH] = rdata;
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Self-checking bench for param_register_file.
// Queued expectations checked on negedge.
module tb_param_register_file;

  logic clk;
  logic rst_n;

  param_register_file_if #(
    .WIDTH(32), .ADDR_W(5), .NRD(2)
  ) bus32 ();
  param_register_file_if #(
    .WIDTH(32), .ADDR_W(5), .NRD(1)
  ) bus24 ();

  param_register_file #(
    .WIDTH(32), .DEPTH(32),
    .NRD(2), .ZERO_REG(1)
  ) u_dut32 (
    .Clk(clk), .Rst_n(rst_n),
    .bus(bus32.slave)
  );

  param_register_file #(
    .WIDTH(32), .DEPTH(24),
    .NRD(1), .ZERO_REG(1)
  ) u_dut24 (
    .Clk(clk), .Rst_n(rst_n),
    .bus(bus24.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PARAM_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic expect_val(
    input string name,
    input int kind,
    input logic [31:0] v
  );
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ra32(input int a0, input int a1);
    bus32.RA = {5'(a1), 5'(a0)};
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       act = bus32.PA[31:0];
        1:       act = bus32.PA[63:32];
        2:       act = {31'b0, bus32.Busy};
        3:       act = {31'b0, bus32.Done};
        default: act = bus24.PA[31:0];
      endcase
      n_chk++;
      if (act === e.exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %h expected %h",
                 e.name, act, e.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    bus32.LE  = 1'b0;
    bus32.RW  = '0;
    bus32.PW  = '0;
    bus32.RA  = '0;
    bus32.Clr = 1'b0;
    bus24.LE  = 1'b0;
    bus24.RW  = '0;
    bus24.PW  = '0;
    bus24.RA  = '0;
    bus24.Clr = 1'b0;
    step();

    expect_val("rst_busy", 2, 0);
    expect_val("rst_done", 3, 0);
    expect_val("rst_p0", 0, 0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      bus32.LE = 1'b1;
      bus32.RW = 5'(i);
      bus32.PW = 32'(20 + i);
      step();
    end
    bus32.LE = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra32(i, i);
      expect_val("sweep_p0", 0,
                 (i == 0) ? 0 : 32'(20 + i));
      expect_val("sweep_p1", 1,
                 (i == 0) ? 0 : 32'(20 + i));
      step();
    end

    for (int i = 0; i < 32; i++) begin
      bus32.LE = 1'b0;
      bus32.RW = 5'(i);
      bus32.PW = 32'(55 + i);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      ra32(i, 31 - i);
      expect_val("le0_p0", 0,
                 (i == 0) ? 0 : 32'(20 + i));
      expect_val("le0_p1", 1,
                 (i == 31) ? 0 : 32'(51 - i));
      step();
    end

    ra32(5, 3);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus32.PA === 64'h0) n_pass++;
    else $display("FAIL arst_now_pa: %h", bus32.PA);
    n_chk++;
    if (bus32.Busy === 1'b0 && bus32.Done === 1'b0)
      n_pass++;
    else $display("FAIL arst_now_bd");
    expect_val("arst_p0", 0, 0);
    expect_val("arst_p1", 1, 0);
    expect_val("arst_busy", 2, 0);
    expect_val("arst_done", 3, 0);
    step();
    rst_n = 1'b1;
    expect_val("post_rst_p1", 1, 0);
    step();

    bus32.LE = 1'b1;
    bus32.RW = 5'd7;
    bus32.PW = 32'h1111;
    step();
    bus32.PW = 32'h1234;
    ra32(7, 0);
    #1;
    n_chk++;
    if (bus32.PA[31:0] ===
        (BYP ? 32'h1234 : 32'h1111))
      n_pass++;
    else $display("FAIL byp_now: %h", bus32.PA[31:0]);
    expect_val("byp_p0", 0,
               BYP ? 32'h1234 : 32'h1111);
    expect_val("byp_p1", 1, 0);
    step();
    bus32.LE = 1'b0;
    expect_val("byp_after", 0, 32'h1234);
    step();
    bus32.LE = 1'b1;
    bus32.RW = 5'd0;
    bus32.PW = 32'hBEEF;
    ra32(0, 0);
    expect_val("byp_r0", 0, 0);
    step();
    bus32.LE = 1'b0;
    expect_val("r0_after", 0, 0);
    step();

    for (int i = 0; i < 32; i++) begin
      bus32.LE = 1'b1;
      bus32.RW = 5'(i);
      bus32.PW = 32'hFFFF_FFFF;
      step();
    end
    bus32.Clr = 1'b1;
    bus32.RW  = 5'd5;
    bus32.PW  = 32'h5555;
    ra32(5, 5);
    expect_val("clr_idle_busy", 2, 0);
    expect_val("clr_idle_p0", 0, 32'hFFFF_FFFF);
    step();
    for (int k = 0; k < 31; k++) begin
      bus32.Clr = 1'b1;
      bus32.LE  = 1'b1;
      bus32.RW  = 5'd1;
      bus32.PW  = 32'hDEAD;
      expect_val("clr_busy", 2, 1);
      expect_val("clr_done", 3, 0);
      if (k == 0)
        expect_val("clr_same_edge_wr", 0, 32'h5555);
      step();
    end
    bus32.Clr = 1'b0;
    bus32.LE  = 1'b0;
    expect_val("done_busy", 2, 0);
    expect_val("done_pulse", 3, 1);
    step();
    expect_val("idle_busy", 2, 0);
    expect_val("idle_done", 3, 0);
    step();
    for (int i = 0; i < 32; i++) begin
      ra32(i, 31 - i);
      expect_val("cleared_p0", 0, 0);
      expect_val("cleared_p1", 1, 0);
      step();
    end

    bus32.LE = 1'b1;
    bus32.RW = 5'd9;
    bus32.PW = 32'h99;
    step();
    bus32.RW = 5'd30;
    bus32.PW = 32'h3030;
    step();
    bus32.LE  = 1'b0;
    bus32.Clr = 1'b1;
    ra32(9, 30);
    expect_val("pre_mid_p0", 0, 32'h99);
    expect_val("pre_mid_p1", 1, 32'h3030);
    step();
    bus32.Clr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_val("mid_busy", 2, 1);
      step();
    end
    rst_n = 1'b0;
    expect_val("mid_rst_busy", 2, 0);
    expect_val("mid_rst_done", 3, 0);
    expect_val("mid_rst_p0", 0, 0);
    expect_val("mid_rst_p1", 1, 0);
    step();
    rst_n     = 1'b1;
    bus32.Clr = 1'b1;
    expect_val("restart_idle", 2, 0);
    step();
    bus32.Clr = 1'b0;
    for (int k = 0; k < 31; k++) begin
      expect_val("restart_busy", 2, 1);
      expect_val("restart_done", 3, 0);
      step();
    end
    expect_val("restart_end_busy", 2, 0);
    expect_val("restart_end_done", 3, 1);
    step();
    expect_val("restart_idle_done", 3, 0);
    step();

    bus24.LE = 1'b1;
    bus24.RW = 5'd25;
    bus24.PW = 32'hAA;
    step();
    bus24.LE = 1'b0;
    bus24.RA = 5'd25;
    expect_val("d24_oob_25", 4, 0);
    step();
    bus24.RA = 5'd9;
    expect_val("d24_alias_9", 4, 0);
    step();
    bus24.LE = 1'b1;
    bus24.RW = 5'd23;
    step();
    bus24.LE = 1'b0;
    bus24.RA = 5'd23;
    expect_val("d24_r23", 4, 32'hAA);
    step();
    bus24.RA = 5'd24;
    expect_val("d24_oob_24", 4, 0);
    step();
    step();

    if (n_chk > 0 && n_pass == n_chk)
      $display("PASS");
    else
      $display("FAIL summary");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised multi-read-port general register file for the PA-RISC datapath; the generalised successor of the fixed 32×32 three-port file. Provides NRD combinational read ports and one synchronous write port, an optional hardwired-zero register 0, a sequential bulk-clear engine with busy/done handshake, and compile-time write-to-read bypass. Sits between decode (register addresses) and execute (operands), with writeback driving the write port.

## Interface

- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (2..256, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived, do not override)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

- Clk  input  1  rising-edge clock; one clock; all state on this edge
- Rst_n  input  1  asynchronous, active-low reset
- LE  input  1  write enable
- RW  input  ADDR_W  write address
- PW  input  WIDTH  write data
- RA  input  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- PA  output  NRD*WIDTH  read data, port i at bits [i*WIDTH +: WIDTH]
- Clr  input  1  bulk-clear request, sampled on Clk
- Busy  output  1  high while clear engine is running
- Done  output  1  one-cycle pulse when clear finishes

## Operation

- Reads: combinational from storage; address >= DEPTH reads 0; address 0 reads 0 when ZERO_REG=1.
- Writes: on rising Clk when LE=1, state not CLEAR, RW < DEPTH, and not (ZERO_REG=1 and RW=0); otherwise dropped silently.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: Clr=1 at an edge -> CLEAR, pointer loaded with first address (1 if ZERO_REG else 0). A write with LE=1 at that same edge is performed.
  - CLEAR: each edge writes 0 to register[pointer], pointer+1; after writing DEPTH-1 -> DONE. Clr ignored. External writes dropped.
  - DONE: one cycle; writes accepted; Clr ignored; -> IDLE unconditionally.
- Busy = (state==CLEAR); Done = (state==DONE). Both registered-state decodes, no combinational path from inputs.
- Reads during CLEAR return current storage (mix of cleared and uncleared registers); no masking.
- Reset (Rst_n=0, any time incl. mid-clear): all registers 0, state IDLE, pointer 0; Busy=0, Done=0, every PA lane 0. Leaves reset on the first edge with Rst_n=1.

## Timing

- Read latency: 0 cycles (combinational address-to-data).
- Write latency: data visible on read ports after the writing edge (1 cycle), unless bypassed (see Configuration).
- Clear duration: DEPTH-1 cycles in CLEAR when ZERO_REG=1, DEPTH otherwise; Done high the cycle after the last clear write; Busy falls on the same edge Done rises.
- Clr held high: accepted once; re-accepted only after returning to IDLE (earliest: edge after DONE).

## Configuration

- Macro PARAM_RF_BYPASS_EN.
- Defined: each read port i returns PW combinationally when LE=1, state != CLEAR, RW < DEPTH, RA[i]==RW, and RW is writable (not zero with ZERO_REG=1); otherwise storage. Gives same-cycle writeback-to-operand forwarding.
- Undefined: no bypass; read ports always return storage; same-cycle read of the written address returns the old value.

## Test plan

- Reset: Rst_n=0 with storage previously loaded -> all PA lanes 0, Busy=0, Done=0 immediately (no clock edge required).
- Write/read sweep (DEPTH=32, NRD=2): write PW=20+i to RW=i for i=0..31 with LE=1, then read -> register 0 reads 0, register i reads 20+i for i>=1 on both ports; repeat with LE=0, PW=55.. -> contents unchanged.
- Non-power-of-two (DEPTH=24): write 0xAA to RW=25 -> ignored; RA=25 reads 0; RW=23 writes and reads back 0xAA.
- Bulk clear (DEPTH=32, ZERO_REG=1): fill registers with 0xFFFFFFFF, pulse Clr -> Busy high exactly 31 cycles, Done one-cycle pulse after, all registers read 0; LE=1 writes during Busy are dropped; Clr with LE=1 to RW=5 in IDLE still ends with register 5 = 0.
- Reset mid-clear: assert Rst_n=0 at clear cycle 10 -> Busy and Done 0 immediately, all registers 0, next Clr restarts full 31-cycle sequence.
- Bypass: LE=1, RW=7, PW=0x1234, RA port0=7 before the edge -> with PARAM_RF_BYPASS_EN port0 reads 0x1234 same cycle; without, old value until after the edge; RW=0 never bypasses (reads 0).
